inst_mem_server: RTL
====================

// Module: inst_mem_server
// PURPOSE
//  Instruction-side responder for the core: answers the core's fetch requests with 32-bit RV32I words.
//  Program bytes arrive from the host loader as a little-endian byte stream and are packed into a word RAM.
//  Two phases: LOAD (host writes the program), then RUN (core fetches).
// PARAMETERS
//  ADDR_WIDTH  10  log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB)
// PORTS
//  clk          in   1             system clock, all logic on posedge
//  rstn         in   1             asynchronous active-low reset
//  ld_valid     in   1             ld_byte valid this cycle (LOAD phase only)
//  ld_byte      in   8             program byte, little-endian order, address increasing
//  ld_done      in   1             one-cycle pulse: program complete, enter RUN
//  fetch_req    in   1             core fetch request this cycle (RUN phase only)
//  fetch_pc     in   32            byte address of requested instruction
//  fetch_ack    out  1             one-cycle pulse: fetch_instr/fetch_err valid
//  fetch_instr  out  32            fetched instruction word
//  fetch_err    out  1             qualifies fetch_ack: misaligned or unloaded address
//  loaded       out  1             high in RUN phase
//  load_words   out  ADDR_WIDTH+1  number of words written during LOAD
//  ld_overflow  out  1             sticky: a byte was dropped because RAM was full
// BEHAVIOUR
//  Reset (async, rstn=0): state=LOAD; fetch_ack=0, fetch_instr=0, fetch_err=0, loaded=0,
//   load_words=0, ld_overflow=0; byte lane counter=0; word staging register=0. RAM contents are
//   not cleared; they are unreachable because load_words=0.
//  States: LOAD -> RUN on ld_done. RUN is left only by reset. No other transitions.
//  LOAD phase:
//   - Each ld_valid byte goes to lane k (k=0..3) of the staging word, bits [8k+7:8k]; k increments.
//   - When lane 3 is filled, in the same cycle the full word {b3,b2,b1,b0} is written to RAM[load_words]
//     and load_words increments; k wraps to 0.
//   - RAM full (load_words == 2**ADDR_WIDTH): further bytes are dropped and ld_overflow is set (sticky).
//   - ld_done with k!=0: the partial word is written with the unfilled upper lanes zero, load_words
//     increments (unless full), then RUN.
//   - ld_valid and ld_done in the same cycle: the byte is taken first, then the partial-word flush rule
//     applies, then RUN. loaded rises the cycle after ld_done.
//   - fetch_req in LOAD is ignored: no fetch_ack is ever produced for it.
//  RUN phase:
//   - ld_valid/ld_done are ignored; load_words and ld_overflow hold.
//   - Fetch is pipelined: a request sampled on edge N yields fetch_ack=1 in the cycle after edge N+1
//     (1-cycle latency, registered outputs); a new request is accepted every cycle, with no stall.
//   - Word index = fetch_pc[ADDR_WIDTH+1:2].
//   - fetch_err=1 when fetch_pc[1:0]!=0, or fetch_pc[31:2] >= load_words (which includes any high bits
//     beyond RAM).
//   - On error, fetch_instr=32'h0000_0013 (addi x0,x0,0 / NOP) and no RAM value is exposed.
//   - On success, fetch_err=0 and fetch_instr=RAM word.
//   - In cycles without an ack, fetch_ack=0 and fetch_instr/fetch_err hold their last values.
//  Reset mid-operation: all outputs and phase return to reset values immediately (async), and any
//   in-flight fetch is discarded: no fetch_ack after reset deasserts.
//  RAM: single write port (LOAD) and single synchronous read port (RUN), inferable as block RAM.
// TESTING
//  T1 load bytes 13 00 00 00 B3 00 11 00 then ld_done -> load_words=2, loaded=1 next cycle, ld_overflow=0
//  T2 after T1, fetch_pc=0 then 4 on consecutive cycles -> acks on consecutive cycles:
//     32'h0000_0013 then 32'h0011_00B3, fetch_err=0
//  T3 after T1, fetch_pc=2 -> ack, err=1, instr=32'h0000_0013; fetch_pc=8 -> ack, err=1
//  T4 load 3 bytes EF BE AD, ld_done with ld_valid and byte DE -> load_words=1, fetch 0 -> 32'hDEAD_BEEF;
//     load 3 bytes AA BB CC then ld_done -> fetch 0 -> 32'h00CC_BBAA
//  T5 ADDR_WIDTH=2: stream 20 bytes -> load_words=4, ld_overflow=1, fetch 16 -> err=1
//  T6 assert rstn=0 after 6 bytes of LOAD and again during a RUN fetch -> outputs zero at once, no ack
//     follows, load_words=0

Source files
------------

// File: rtl/inst_mem_server.sv
// Instruction memory server: packs a little-endian program byte stream into a word RAM (LOAD),
// then answers pipelined core fetches with one-cycle latency and error/NOP substitution (RUN).
// Ports: clk, rstn | ld_valid, ld_byte, ld_done (loader) | fetch_req, fetch_pc (core request)
//        fetch_ack, fetch_instr, fetch_err (response) | loaded, load_words, ld_overflow (status)
module inst_mem_server #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_done,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_pc,
    output logic                  fetch_ack,
    output logic [31:0]           fetch_instr,
    output logic                  fetch_err,
    output logic                  loaded,
    output logic [ADDR_WIDTH:0]   load_words,
    output logic                  ld_overflow
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {S_LOAD, S_RUN} state_e;

    state_e                state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           stage_q, stage_d;
    logic [ADDR_WIDTH:0]   lw_q, lw_d;
    logic                  ovf_q, ovf_d;

    logic                  we;
    logic [31:0]           wdata;
    logic                  full;
    logic                  req;
    logic                  ferr;

    logic                  pend_q;
    logic                  perr_q;
    logic [31:0]           rdata_q;
    logic                  ack_q;
    logic [31:0]           instr_q;
    logic                  err_q;

    logic [31:0]           mem [2**ADDR_WIDTH];

    // load_words never exceeds 2**ADDR_WIDTH, so its MSB alone flags a full RAM.
    assign full = lw_q[ADDR_WIDTH];
    assign req  = fetch_req && (state_q == S_RUN);
    assign ferr = (|fetch_pc[1:0]) ||
                  (fetch_pc[31:2] >= 30'(lw_q));

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        stage_d = stage_q;
        lw_d    = lw_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        wdata   = stage_q;
        if (state_q == S_LOAD) begin
            if (ld_valid) begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    stage_d[{lane_q, 3'b000} +: 8] = ld_byte;
                    lane_d = lane_q + 2'd1;
                end
            end
            wdata = stage_d;
            // A completed word and a flush never coincide: completing wraps the lane to 0.
            if (ld_valid && !full && lane_q == 2'd3) begin
                we = 1'b1;
            end else if (ld_done && lane_d != 2'd0 && !full) begin
                we = 1'b1;
            end
            if (we) begin
                lw_d    = lw_q + (ADDR_WIDTH+1)'(1);
                stage_d = '0;
                lane_d  = 2'd0;
            end
            if (ld_done) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_LOAD;
            lane_q  <= 2'd0;
            stage_q <= '0;
            lw_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            stage_q <= stage_d;
            lw_q    <= lw_d;
            ovf_q   <= ovf_d;
        end
    end

    // RAM kept free of reset so it maps onto a block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[lw_q[ADDR_WIDTH-1:0]] <= wdata;
        end
        if (req) begin
            rdata_q <= mem[fetch_pc[ADDR_WIDTH+1:2]];
        end
    end

    // Stage 1 tracks the RAM read; stage 2 registers the response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q  <= 1'b0;
            perr_q  <= 1'b0;
            ack_q   <= 1'b0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pend_q <= req;
            if (req) begin
                perr_q <= ferr;
            end
            ack_q <= pend_q;
            if (pend_q) begin
                instr_q <= perr_q ? NOP : rdata_q;
                err_q   <= perr_q;
            end
        end
    end

    assign fetch_ack   = ack_q;
    assign fetch_instr = instr_q;
    assign fetch_err   = err_q;
    assign loaded      = (state_q == S_RUN);
    assign load_words  = lw_q;
    assign ld_overflow = ovf_q;

endmodule
